// File: rtl/uart_pkg.sv
// Shared UART constants used by uart_fifo, the UART blocks and interfaz.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_FIFO_ADDR_BITS = 4;

endpackage

// File: rtl/uart_fifo_ctrl.sv
// Pointer, flag and optional level bookkeeping for uart_fifo.
// Optional occupancy counter enabled by UART_FIFO_LEVEL_EN.
module uart_fifo_ctrl #(
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic                 rd,
  output logic                 empty,
  output logic                 full,
  output logic                 w_en_c,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic [ADDR_BITS-1:0] r_addr
`ifdef UART_FIFO_LEVEL_EN
  ,
  output logic [ADDR_BITS:0]   level
`endif
);

  logic [ADDR_BITS-1:0] w_ptr, w_ptr_nxt, w_ptr_succ;
  logic [ADDR_BITS-1:0] r_ptr, r_ptr_nxt, r_ptr_succ;
  logic                 empty_nxt, full_nxt;
  logic                 wr_acc, rd_acc;

  // A write into a full FIFO is accepted only when a pop frees the head slot.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd);

  assign w_ptr_succ = w_ptr + ADDR_BITS'(1);
  assign r_ptr_succ = r_ptr + ADDR_BITS'(1);

  assign w_en_c = wr_acc;
  assign w_addr = w_ptr;
  assign r_addr = r_ptr;

  always_comb begin
    w_ptr_nxt = w_ptr;
    r_ptr_nxt = r_ptr;
    empty_nxt = empty;
    full_nxt  = full;
    case ({wr_acc, rd_acc})
      2'b11: begin
        w_ptr_nxt = w_ptr_succ;
        r_ptr_nxt = r_ptr_succ;
      end
      2'b10: begin
        w_ptr_nxt = w_ptr_succ;
        empty_nxt = 1'b0;
        full_nxt  = (w_ptr_succ == r_ptr);
      end
      2'b01: begin
        r_ptr_nxt = r_ptr_succ;
        full_nxt  = 1'b0;
        empty_nxt = (r_ptr_succ == w_ptr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      w_ptr <= w_ptr_nxt;
      r_ptr <= r_ptr_nxt;
      empty <= empty_nxt;
      full  <= full_nxt;
    end
  end

`ifdef UART_FIFO_LEVEL_EN
  logic [ADDR_BITS:0] level_nxt;

  always_comb begin
    level_nxt = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + (ADDR_BITS+1)'(1);
      2'b01:   level_nxt = level - (ADDR_BITS+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) level <= '0;
    else        level <= level_nxt;
  end
`endif

endmodule

// File: rtl/uart_fifo.sv
// First-word fall-through byte FIFO between the UART and interfaz.
// Define UART_FIFO_LEVEL_EN to add the level occupancy output.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS,
  parameter int unsigned ADDR_BITS = UART_FIFO_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 empty,
  output logic                 full
`ifdef UART_FIFO_LEVEL_EN
  ,
  output logic [ADDR_BITS:0]   level
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 w_en_c;
  logic [ADDR_BITS-1:0] w_addr, r_addr;

  uart_fifo_ctrl #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .empty  (empty),
    .full   (full),
    .w_en_c (w_en_c),
    .w_addr (w_addr),
    .r_addr (r_addr)
`ifdef UART_FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  // Storage is intentionally not reset; the flags alone define validity.
  always_ff @(posedge clk) begin
    if (w_en_c) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo against a queue-based reference model.
module tb_uart_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr, rd;
  logic [7:0] w_data;
  logic [7:0] r_data;
  logic       empty, full;
`ifdef UART_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] q[$];

  uart_fifo dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .w_data (w_data),
    .rd     (rd),
    .r_data (r_data),
    .empty  (empty),
    .full   (full)
`ifdef UART_FIFO_LEVEL_EN
    ,
    .level  (level)
`endif
  );

  always #5 clk = ~clk;

  // One clock with the given strobes; the model follows the FIFO rules.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    bit acc_r, acc_w;
    acc_r = r && (q.size() != 0);
    acc_w = w && ((q.size() < DEPTH) || acc_r);
    wr = w; rd = r; w_data = d;
    @(posedge clk); #1;
    if (acc_r) void'(q.pop_front());
    if (acc_w) q.push_back(d);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;
    #12;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
`ifdef UART_FIFO_LEVEL_EN
    n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    cycle(1'b1, 1'b0, 8'h01);
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%b exp=0", empty); end
    n_cmp++; if (r_data !== 8'h01) begin n_fail++; $display("FAIL single_data got=%h exp=01", r_data); end
    cycle(1'b0, 1'b1, 8'h00);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 14) begin
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL fill_early_full got=%b exp=0", full); end
      end
    end
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got=%b exp=1", full); end
    cycle(1'b1, 1'b0, 8'hAA);
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_full got=%b exp=1", full); end
    n_cmp++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL fill_ovf_head got=%h exp=00", r_data); end
`ifdef UART_FIFO_LEVEL_EN
    n_cmp++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill_level got=%0d exp=16", level); end
`endif
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (r_data !== 8'(i)) begin n_fail++; $display("FAIL fill_order idx=%0d got=%h exp=%h", i, r_data, 8'(i)); end
      cycle(1'b0, 1'b1, 8'h00);
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drain_empty got=%b exp=1", empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (r_data !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, r_data, 8'(8'h40 + i)); end
      cycle(1'b0, 1'b1, 8'h00);
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_simul_empty();
    cycle(1'b1, 1'b1, 8'h55);
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL simul_empty_flag got=%b exp=0", empty); end
    n_cmp++; if (r_data !== 8'h55) begin n_fail++; $display("FAIL simul_empty_data got=%h exp=55", r_data); end
    cycle(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_simul_full();
    logic [7:0] nb;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom));
    for (int k = 0; k < 3; k++) begin
      nb = 8'($urandom);
      cycle(1'b1, 1'b1, nb);
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_full_flag got=%b exp=1", full); end
      n_cmp++; if (r_data !== q[0]) begin n_fail++; $display("FAIL simul_full_head got=%h exp=%h", r_data, q[0]); end
    end
    while (q.size() != 0) begin
      n_cmp++; if (r_data !== q[0]) begin n_fail++; $display("FAIL simul_full_order got=%h exp=%h", r_data, q[0]); end
      cycle(1'b0, 1'b1, 8'h00);
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_full_drain got=%b exp=1", empty); end
  endtask

  task automatic test_rd_empty();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rd_empty_flag got=%b exp=1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rd_empty_full got=%b exp=0", full); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL mid_pre_empty got=%b exp=0", empty); end
    wr = 1'b1; w_data = 8'h77;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL mid_reset_full got=%b exp=0", full); end
`ifdef UART_FIFO_LEVEL_EN
    n_cmp++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_reset_level got=%0d exp=0", level); end
`endif
    wr = 1'b0;
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_after_empty got=%b exp=1", empty); end
  endtask

  task automatic test_interfaz();
    cycle(1'b1, 1'b0, 8'h01);
    n_cmp++; if (empty !== 1'b0 || r_data !== 8'h01) begin n_fail++; $display("FAIL ifz_ready got=%b/%h exp=0/01", empty, r_data); end
    cycle(1'b0, 1'b1, 8'h00);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ifz_consumed got=%b exp=1", empty); end
    cycle(1'b0, 1'b0, 8'h00);
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ifz_idle got=%b exp=1", empty); end
  endtask

  task automatic test_random();
    logic w, r;
    for (int i = 0; i < 600; i++) begin
      // Alternate bias so the run spends time near both full and empty.
      if ((i / 100) % 2 == 0) begin
        w = ($urandom_range(0, 9) < 7); r = ($urandom_range(0, 9) < 3);
      end else begin
        w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 7);
      end
      cycle(w, r, 8'($urandom));
      n_cmp++; if (empty !== (q.size() == 0)) begin n_fail++; $display("FAIL rand_empty cyc=%0d got=%b exp=%b", i, empty, q.size() == 0); end
      n_cmp++; if (full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rand_full cyc=%0d got=%b exp=%b", i, full, q.size() == DEPTH); end
      if (q.size() != 0) begin
        n_cmp++; if (r_data !== q[0]) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, r_data, q[0]); end
      end
`ifdef UART_FIFO_LEVEL_EN
      n_cmp++; if (level !== 5'(q.size())) begin n_fail++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, q.size()); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_simul_empty();
    test_simul_full();
    test_rd_empty();
    test_reset_mid();
    test_interfaz();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Byte FIFO sitting between the UART receiver/transmitter and the `interfaz` ALU sequencer. It is the responder end of the `rd_uart`/`rx_empty` (receive side) and `wr_uart`/`tx_full` (transmit side) handshakes. One instance buffers received bytes for `interfaz`; a second buffers `interfaz` results for the transmitter. The read port is first-word fall-through: the head byte is always visible on `r_data` while `empty` is low.

## Interface
- `DATA_BITS`, 8: byte width.
- `ADDR_BITS`, 4: depth is 2^ADDR_BITS entries (16).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr`  in  1  push strobe, one cycle per byte.
- `w_data`  in  DATA_BITS  byte to push, sampled with `wr`.
- `rd`  in  1  pop strobe, one cycle per byte.
- `r_data`  out  DATA_BITS  head byte, valid while `empty`=0.
- `empty`  out  1  no bytes stored; drives `rx_empty` on the receive instance.
- `full`  out  1  2^ADDR_BITS bytes stored; drives `tx_full` on the transmit instance.
- `level`  out  ADDR_BITS+1  occupancy, 0..2^ADDR_BITS (only with `UART_FIFO_LEVEL_EN`).

## Operation
- Storage: register array of 2^ADDR_BITS x DATA_BITS entries; not reset.
- Write pointer `w_ptr` and read pointer `r_ptr` are ADDR_BITS wide and wrap modulo 2^ADDR_BITS.
- Registered flags: `empty_reg` and `full_reg`.
- Reset (`reset`=0, asynchronous): `w_ptr`=0, `r_ptr`=0, `empty`=1, `full`=0, `level`=0. `r_data` is don't-care while empty.
- Per-edge behaviour, based on {`wr`,`rd`}:
  - 00: hold.
  - 10, not full: `mem[w_ptr]`<=`w_data`, `w_ptr`++, `empty`<=0; `full`<=1 if `w_ptr`+1==`r_ptr`.
  - 10, full: ignored. No pointer change and no data corruption.
  - 01, not empty: `r_ptr`++, `full`<=0; `empty`<=1 if `r_ptr`+1==`w_ptr`.
  - 01, empty: ignored.
  - 11, empty: write only; the read is ignored.
  - 11, full: both take effect (pop head, push new). `full` stays 1.
  - 11, otherwise: both pointers advance. Flags and level are unchanged.
- `r_data` = `mem[r_ptr]`, a combinational read of the array.

## Timing
- Write-to-read latency: a byte pushed at edge N appears on `r_data` with `empty`=0 after edge N (one cycle).
- Pop: after edge N with `rd`=1, `r_data` shows the next byte, or `empty`=1 if none remain.
- `full` and `empty` are registered and update on the same edge as the pointer move.
- `rd` and `wr` are single-cycle strobes. A strobe held high for k cycles performs k operations, subject to the full/empty rules above.
- Reset mid-operation: contents are discarded logically, and flags return to their reset values immediately.

## Configuration
- `UART_FIFO_LEVEL_EN` defined: adds the `level` output port. It is an (ADDR_BITS+1)-bit counter:
  - +1 on an accepted write alone.
  - −1 on an accepted read alone.
  - Unchanged on simultaneous accepted read and write.
  - Reset value 0. Must equal the number of stored bytes at all times.
- Not defined: `level` port and counter are absent. Flags come from pointer comparison only, and behaviour is otherwise identical.

## Structure
- Shared package `uart_pkg` holds `UART_DATA_BITS`=8 and `UART_FIFO_ADDR_BITS`=4. `interfaz` and the UART blocks use the same constants.
- Sub-module `uart_fifo_ctrl`: pointers, flags, level counter, and write-enable generation.
- The top `uart_fifo` holds the register array and the read mux.

## Test plan
- Reset, then write 0x01 with `rd`=0 → the cycle after the write edge, `empty`=0 and `r_data`=0x01. Then `rd` for one cycle → `empty`=1.
- Write 16 bytes 0x00..0x0F → `full`=1 after the 16th edge. A 17th write of 0xAA is ignored. Reading 16 bytes returns 0x00..0x0F in order, then `empty`=1.
- Wrap: write 10 bytes, read 10, then write 10 bytes (0x40..0x49) → pointers wrap past 15, and reads return 0x40..0x49 in order.
- Simultaneous `rd`/`wr`:
  - While empty, with `w_data`=0x55 → byte stored, `empty`=0, `r_data`=0x55.
  - While full → head popped, new byte appended, `full` stays 1, order preserved.
- Read on empty with `rd` held 3 cycles → no change, `empty`=1. Then assert `reset`=0 mid-burst after 5 writes → `empty`=1 and `full`=0 immediately, and `level`=0 with `UART_FIFO_LEVEL_EN`.
- `interfaz` pattern: `rx_empty` drops for one cycle with `r_data`=0x01 and `rd` pulsed → exactly one byte consumed, and `empty` returns to 1.
